mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS core, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles into dedicated HI/LO registers.
- Also supports direct HI/LO writes for MTHI/MTLO.
- Exposes busy/done so the control path can stall MFHI/MFLO and new mult/div issues until the result is ready.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_iter_datapath.sv | 50 +++++
 rtl/mult_div_unit.sv | 136 +++++++++++++
 tb/tb_mult_div_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_datapath.sv
// Shared 2*WIDTH shift register: one unsigned shift-add multiply or
// restoring shift-subtract divide step per enabled cycle.
module mdu_iter_datapath
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply consumes multiplier bits from acc[0]; divide shifts dividend bits
  // into the remainder half and shifts quotient bits in at the bottom.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    acc_next = acc;
    if (!is_div) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      b_q <= '0;
    end else if (load) begin
      acc <= {WIDTH'(0), a};
      b_q <= b;
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_e         state, state_next;
  logic [CW-1:0]      count;
  mdu_op_e            op_q;
  logic               res_neg;
  logic               rem_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   raw_a;
  logic               issue;
  logic               op_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand conditioning at issue: signed ops iterate on magnitudes.
  always_comb begin
    issue     = (state == IDLE) && start;
    op_signed = !op[0];
    a_abs     = (op_signed && src_a[WIDTH-1]) ? WIDTH'(-src_a) : src_a;
    b_abs     = (op_signed && src_b[WIDTH-1]) ? WIDTH'(-src_b) : src_b;
  end

  mdu_iter_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (issue),
    .step   (state == CALC),
    .is_div (op_q[1]),
    .a      (a_abs),
    .b      (b_abs),
    .acc    (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction; divide by zero returns the raw dividend and all-ones.
  always_comb begin
    prod   = (op_q == MDU_MULT && res_neg) ? (2*WIDTH)'(-acc) : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      fix_lo = (op_q == MDU_DIV && res_neg) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      fix_hi = (op_q == MDU_DIV && rem_neg) ? WIDTH'(-acc[2*WIDTH-1:WIDTH])
                                            : acc[2*WIDTH-1:WIDTH];
      if (b_zero) begin
        fix_lo = '1;
        fix_hi = raw_a;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      op_q     <= MDU_MULT;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      b_zero   <= 1'b0;
      raw_a    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (issue) begin
        count    <= '0;
        op_q     <= mdu_op_e'(op);
        res_neg  <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        rem_neg  <= op_signed && src_a[WIDTH-1];
        b_zero   <= (src_b == '0);
        raw_a    <= src_a;
        div_zero <= 1'b0;
      end else if (state == CALC) begin
        count <= count + CW'(1);
      end else if (state == FIX) begin
        div_zero <= op_q[1] && b_zero;
      end
    end
  end

  // HI/LO: direct writes only while idle; operation results land at FIX exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state == IDLE) begin
      if (wr_hi) hi <= wd;
      if (wr_lo) lo <= wd;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wd;
  logic        wr_hi, wr_lo;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Issues one op; lat = cycle (1 = after the start edge) where done is seen, 0 on timeout.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0; src_a = $urandom; src_b = $urandom;
    lat = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; op = 0; src_a = 0; src_b = 0; wr_hi = 0; wr_lo = 0; wd = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu;
    int lat; bit bok;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
    checks++; if (lat != 34) begin errors++; $display("FAIL multu_latency got %0d want 34", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL multu_busy got low want high throughout"); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL multu_after busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_mult;
    int lat; bit bok;
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, bok);
    checks++; if (lat != 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
  endtask

  task automatic test_div;
    int lat; bit bok;
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bok);
    checks++; if (lat != 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_q got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_r got %h want ffffffff", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_dz got %b want 0", div_zero); end
    issue(2'b11, 32'd100, 32'd7, lat, bok);
    checks++; if (lo !== 32'h0000_000E) begin errors++; $display("FAIL divu_q got %h want 0000000e", lo); end
    checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL divu_r got %h want 00000002", hi); end
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_q got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_r got %h want 0", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got %b want 0", div_zero); end
  endtask

  task automatic test_div_zero;
    int lat; bit bok;
    issue(2'b11, 32'h1234_5678, 32'h0, lat, bok);
    checks++; if (lat != 34) begin errors++; $display("FAIL dz_latency got %0d want 34", lat); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL dz_hi got %h want 12345678", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h want ffffffff", lo); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
    repeat (3) @(negedge clk);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %b want 1", div_zero); end
    issue(2'b01, 32'd1, 32'd1, lat, bok);
    checks++; if (div_zero !== 1'b0 || lo !== 32'd1) begin errors++; $display("FAIL dz_clear dz=%b lo=%h want 0 00000001", div_zero, lo); end
  endtask

  task automatic test_busy_rules;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
      if (n == 5) begin
        start = 1'b1; op = 2'b11; src_a = 32'd50; src_b = 32'd9; wr_hi = 1'b1; wd = 32'hAAAA_5555;
      end else if (n == 6) begin
        start = 1'b0; wr_hi = 1'b0;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_wr_hi got %h want 0", hi); end
      end
    end
    checks++; if (lat != 34) begin errors++; $display("FAIL busy_latency got %0d want 34", lat); end
    checks++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL busy_result hi=%h lo=%h want 0 6", hi, lo); end
    @(negedge clk);
    wr_lo = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    wr_lo = 1'b0;
    checks++; if (lo !== 32'h1234 || hi !== 32'd0) begin errors++; $display("FAIL idle_wr_lo lo=%h hi=%h want 1234 0", lo, hi); end
  endtask

  task automatic test_reset_midop;
    int lat; bit bok;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midop_rst busy=%b done=%b want 0 0", busy, done); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midop_rst hi=%h lo=%h want 0 0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    issue(2'b01, 32'd4, 32'd5, lat, bok);
    checks++; if (lat != 34 || !bok) begin errors++; $display("FAIL post_rst_latency got %0d busy_ok=%b want 34 1", lat, bok); end
    checks++; if (lo !== 32'd20 || hi !== 32'd0) begin errors++; $display("FAIL post_rst_result hi=%h lo=%h want 0 14", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_rules();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
